// File: rtl/lamp_pkg.sv
// -----------------------------------------------------------------------------
// lamp_pkg
//   Shared definitions for the lamp controller family.
//   - Scheduler state encodings (IDLE, GRANT, GAP) as plain 2-bit constants
//   - cw(): counter/index width helper ($clog2 clamped to at least 1 bit)
// -----------------------------------------------------------------------------
package lamp_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  // Width needed to hold values 0..n-1. A single-value range still needs one
  // bit so that counters with PRESC=1 or HOLD=1 stay legal vectors.
  function automatic int cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lamp_tick_gen.sv
// -----------------------------------------------------------------------------
// lamp_tick_gen
//   Free-running prescaler. Produces a one-cycle tick every PRESC clocks; the
//   divide-by-2 toggle of the older lamp FSMs is the PRESC=2 case.
//   Ports:
//     CLK   in   system clock, rising edge
//     reset in   asynchronous, active-high reset (counter returns to 0)
//     tick  out  high in the last cycle of each PRESC-cycle period
// -----------------------------------------------------------------------------
module lamp_tick_gen
  import lamp_pkg::*;
#(
  parameter int PRESC = 2
) (
  input  logic CLK,
  input  logic reset,
  output logic tick
);

  localparam int PW = cw(PRESC);
  localparam logic [PW-1:0] LAST = PW'(PRESC - 1);

  logic [PW-1:0] presc_cnt;

  // NOTE: sequential state is assigned with <= so every flop samples values
  // from before the edge; the reset branch is in the sensitivity list, which
  // is what makes it asynchronous.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      presc_cnt <= '0;
    end else if (presc_cnt == LAST) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

  assign tick = (presc_cnt == LAST);

endmodule

// File: rtl/lamp_rr_scheduler.sv
// -----------------------------------------------------------------------------
// lamp_rr_scheduler
//   Time-shares one lamp between N_REQ requesters with round-robin
//   arbitration. A grant lasts up to HOLD ticks (or until its requester
//   releases) and is always followed by one dark GAP tick. All decisions are
//   taken on prescaler ticks only.
//
//   Optional build macro LAMP_PREEMPT0_EN: requester 0 becomes high priority;
//   it preempts any other grant (ptr untouched) and wins at every GAP exit.
//
//   Ports:
//     CLK     in   system clock, rising edge
//     reset   in   asynchronous, active-high reset
//     req     in   level request, bit i = requester i
//     grant   out  registered one-hot (or zero) grant
//     L       out  lamp drive, OR of grant
//     busy    out  high while in GRANT or GAP
//     cur_id  out  index of the current or last granted requester
// -----------------------------------------------------------------------------
module lamp_rr_scheduler
  import lamp_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int HOLD  = 8,
  parameter int PRESC = 2
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  output logic [N_REQ-1:0]       grant,
  output logic                   L,
  output logic                   busy,
  output logic [cw(N_REQ)-1:0]   cur_id
);

  localparam int IDW = cw(N_REQ);
  localparam int HW  = cw(HOLD);
  localparam logic [IDW-1:0]   LAST_ID  = IDW'(N_REQ - 1);
  localparam logic [HW-1:0]    HOLD_TOP = HW'(HOLD - 1);
  localparam logic [N_REQ-1:0] ONE      = {{(N_REQ-1){1'b0}}, 1'b1};

  logic           tick;
  logic [1:0]     state;
  logic [HW-1:0]  hold_cnt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] next_id;

  lamp_tick_gen #(.PRESC(PRESC)) u_tick (
    .CLK   (CLK),
    .reset (reset),
    .tick  (tick)
  );

  // First requester found scanning p, p+1, ... mod N_REQ. The loop runs from
  // the far end back toward p so the nearest hit is the one that sticks.
  function automatic logic [IDW-1:0] pick(input logic [N_REQ-1:0] r,
                                          input logic [IDW-1:0]   p);
    logic [IDW-1:0] sel;
    int             idx;
    sel = p;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = (int'(p) + i) % N_REQ;
      if (r[idx]) sel = IDW'(idx);
    end
    return sel;
  endfunction

  // NOTE: next_id gets its value before any conditional override, so this
  // block can never hold a stale value and infer a latch.
  always_comb begin
    next_id = pick(req, ptr);
`ifdef LAMP_PREEMPT0_EN
    if (state == GAP && req[0]) next_id = '0;
`endif
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      ptr      <= '0;
      grant    <= '0;
      cur_id   <= '0;
    end else if (tick) begin
      case (state)
        IDLE, GAP: begin
          if (|req) begin
            grant    <= ONE << next_id;
            cur_id   <= next_id;
            hold_cnt <= HOLD_TOP;
            state    <= GRANT;
          end else begin
            state    <= IDLE;
          end
        end
        GRANT: begin
`ifdef LAMP_PREEMPT0_EN
          if (cur_id != '0 && req[0]) begin
            // Preemption keeps ptr so the interrupted rotation resumes later.
            grant <= '0;
            state <= GAP;
          end else
`endif
          if (!req[cur_id] || hold_cnt == '0) begin
            grant <= '0;
            ptr   <= (cur_id == LAST_ID) ? '0 : cur_id + 1'b1;
            state <= GAP;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Derived from the registered grant, so an asynchronous reset darkens the
  // lamp immediately.
  assign L    = |grant;
  assign busy = (state != IDLE);

endmodule
